// File: rtl/frame_minmax_pkg.sv
// rtl/frame_minmax_pkg.sv - shared constants and state encoding for frame_minmax_tracker
// Purpose : data/index widths and FSM state type used by the tracker, its
//           interface and the bench.
// Ports   : none (package).
package frame_minmax_pkg;

  localparam int DATA_W = 4;
  localparam int IDX_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/frame_minmax_tracker_if.sv
// rtl/frame_minmax_tracker_if.sv - sample-in / result-out handshake bundle
// Purpose : groups the sample stream and result handshake of the tracker.
// Ports   : master = upstream/downstream driver side, slave = tracker side.
//           in_valid/in_ready/in_data   sample handshake
//           out_valid/out_ready         result handshake
//           out_max/out_min/_idx        extremes and first-occurrence indices
//           out_all_equal               every sample of the frame identical
interface frame_minmax_tracker_if;
  import frame_minmax_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_max;
  logic [DATA_W-1:0] out_min;
  logic [IDX_W-1:0]  out_max_idx;
  logic [IDX_W-1:0]  out_min_idx;
  logic              out_all_equal;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_max, out_min,
           out_max_idx, out_min_idx, out_all_equal
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_max, out_min,
           out_max_idx, out_min_idx, out_all_equal
  );

endinterface

// File: rtl/four_bit_comparator.sv
// rtl/four_bit_comparator.sv - unsigned 4-bit magnitude comparator
// Purpose : pure combinational compare of two unsigned nibbles.
// Ports   : A, B              operands
//           A_greater_than_B  A > B
//           B_greater_than_A  B > A
//           equal             A == B
module four_bit_comparator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_greater_than_B,
  output logic       B_greater_than_A,
  output logic       equal
);

  assign A_greater_than_B = (A > B);
  assign B_greater_than_A = (B > A);
  assign equal            = (A == B);

endmodule

// File: rtl/frame_minmax_tracker.sv
// rtl/frame_minmax_tracker.sv - per-frame min/max/index/all-equal tracker
// Purpose : accumulates FRAME_LEN (2..16) unsigned samples and presents the
//           largest/smallest value, the first index of each, and whether all
//           samples were identical; result held until taken downstream.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           clr  synchronous frame abort (wins over accept and out_ready)
//           bus  frame_minmax_tracker_if.slave sample/result handshake
module frame_minmax_tracker
  import frame_minmax_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  frame_minmax_tracker_if.slave        bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_min;
  logic [IDX_W-1:0]  r_max_idx;
  logic [IDX_W-1:0]  r_min_idx;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_all_eq;

  logic w_in_ready;
  logic w_take;
  logic w_gt_max, w_lt_max, w_eq_max;
  logic w_gt_min, w_lt_min, w_eq_min;
  logic w_unused_cmp;

  four_bit_comparator u_cmp_max (
    .A                (bus.in_data),
    .B                (r_max),
    .A_greater_than_B (w_gt_max),
    .B_greater_than_A (w_lt_max),
    .equal            (w_eq_max)
  );

  four_bit_comparator u_cmp_min (
    .A                (bus.in_data),
    .B                (r_min),
    .A_greater_than_B (w_gt_min),
    .B_greater_than_A (w_lt_min),
    .equal            (w_eq_min)
  );

  // Only the strict-greater vs max, strict-less vs min and equal-to-max
  // outcomes drive the datapath; the rest are intentionally unused.
  assign w_unused_cmp = w_lt_max & w_gt_min & w_eq_min;

  assign w_in_ready = (r_state != ST_HOLD);
  // clr suppresses acceptance in the same cycle.
  assign w_take     = bus.in_valid & w_in_ready & ~clr;

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = (r_state == ST_HOLD);
  assign bus.out_max       = r_max;
  assign bus.out_min       = r_min;
  assign bus.out_max_idx   = r_max_idx;
  assign bus.out_min_idx   = r_min_idx;
  assign bus.out_all_equal = r_all_eq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (clr)                              w_state_nxt = ST_IDLE;
        else if (w_take && r_cnt == LAST_IDX) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        // Leaving HOLD never accepts a sample: one bubble per frame.
        if (clr || bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max     <= '0;
      r_min     <= '0;
      r_max_idx <= '0;
      r_min_idx <= '0;
      r_cnt     <= '0;
      r_all_eq  <= 1'b0;
    end else if (w_take) begin
      if (r_state == ST_IDLE) begin
        r_max     <= bus.in_data;
        r_min     <= bus.in_data;
        r_max_idx <= '0;
        r_min_idx <= '0;
        r_cnt     <= IDX_W'(1);
        r_all_eq  <= 1'b1;
      end else begin
        // r_cnt is the 0-based position of the sample being accepted.
        if (w_gt_max) begin
          r_max     <= bus.in_data;
          r_max_idx <= r_cnt;
        end
        if (w_lt_min) begin
          r_min     <= bus.in_data;
          r_min_idx <= r_cnt;
        end
        if (!w_eq_max) r_all_eq <= 1'b0;
        // Saturate on the last sample so a 16-sample frame never wraps.
        if (r_cnt != LAST_IDX) r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// tb/tb_frame_minmax_tracker.sv - directed self-checking bench for frame_minmax_tracker
module tb_frame_minmax_tracker;
  import frame_minmax_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  frame_minmax_tracker_if bus();
  frame_minmax_tracker_if bus16();

  frame_minmax_tracker #(.FRAME_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  frame_minmax_tracker #(.FRAME_LEN(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus16)
  );

  always #5 clk = ~clk;

  // {out_valid, in_ready, max, max_idx, min, min_idx, all_equal}
  function automatic logic [18:0] snap8();
    return {bus.out_valid, bus.in_ready, bus.out_max, bus.out_max_idx,
            bus.out_min, bus.out_min_idx, bus.out_all_equal};
  endfunction

  function automatic logic [18:0] snap16();
    return {bus16.out_valid, bus16.in_ready, bus16.out_max, bus16.out_max_idx,
            bus16.out_min, bus16.out_min_idx, bus16.out_all_equal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [3:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic release_result(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s_release: valid/ready=%b expected 01", name, {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b0;
    #3;
    total++;
    if (snap8() !== {1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state8: got %h expected %h", snap8(), {1'b0, 1'b1, 17'd0});
    end
    total++;
    if (snap16() !== {1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state16: got %h expected %h", snap16(), {1'b0, 1'b1, 17'd0});
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_mixed();
    logic [3:0] v[8];
    v = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd15, 4'd15, 4'd2};
    for (int i = 0; i < 8; i++) begin
      send_one(v[i]);
      if (i == 6) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL mixed_early_valid: out_valid=%b expected 0", bus.out_valid);
        end
      end
    end
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd15, 4'd5, 4'd0, 4'd4, 1'b0}) begin
      bad++;
      $display("FAIL mixed_result: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd15, 4'd5, 4'd0, 4'd4, 1'b0});
    end
    release_result("mixed");
  endtask

  task automatic test_all_equal();
    for (int i = 0; i < 8; i++) send_one(4'd7);
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd7, 4'd0, 4'd7, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL all_equal_result: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd7, 4'd0, 4'd7, 4'd0, 1'b1});
    end
    release_result("all_equal");
  endtask

  task automatic test_back_pressure();
    logic [3:0]  v[8];
    logic [18:0] exp;
    v = '{4'd4, 4'd2, 4'd8, 4'd8, 4'd1, 4'd6, 4'd1, 4'd3};
    exp = {1'b1, 1'b0, 4'd8, 4'd2, 4'd1, 4'd4, 1'b0};
    for (int i = 0; i < 8; i++) send_one(v[i]);
    // A pending sample of 0 would corrupt min if accepted while holding.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (snap8() !== exp) begin
        bad++;
        $display("FAIL hold_stable_%0d: got %h expected %h", c, snap8(), exp);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL hold_exit: valid/ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    for (int i = 0; i < 8; i++) send_one(4'(i + 4));
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd11, 4'd7, 4'd4, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL after_bubble_result: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd11, 4'd7, 4'd4, 4'd0, 1'b0});
    end
    release_result("back_pressure");
  endtask

  task automatic test_gaps();
    logic [3:0] v[8];
    int acc;
    logic vld;
    v = '{4'd3, 4'd9, 4'd1, 4'd9, 4'd0, 4'd15, 4'd15, 4'd2};
    acc = 0;
    for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
      vld = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus.in_valid = vld;
      bus.in_data  = vld ? v[acc] : 4'd0;
      tick();
      if (vld) acc++;
      total++;
      if (bus.out_valid !== (acc == 8)) begin
        bad++;
        $display("FAIL gaps_valid_cyc%0d: out_valid=%b expected %b", cyc, bus.out_valid, (acc == 8));
      end
    end
    bus.in_valid = 1'b0;
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd15, 4'd5, 4'd0, 4'd4, 1'b0}) begin
      bad++;
      $display("FAIL gaps_result: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd15, 4'd5, 4'd0, 4'd4, 1'b0});
    end
    release_result("gaps");
  endtask

  task automatic test_clr();
    logic [3:0] v[8];
    v = '{4'd6, 4'd8, 4'd7, 4'd8, 4'd6, 4'd9, 4'd9, 4'd7};
    send_one(4'd0); send_one(4'd15); send_one(4'd0); send_one(4'd15);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd3;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL clr_accum: valid/ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
    for (int i = 0; i < 8; i++) begin
      send_one(v[i]);
      if (i == 6) begin
        total++;
        if (bus.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL clr_stale_frame: out_valid=%b expected 0", bus.out_valid);
        end
      end
    end
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd9, 4'd5, 4'd6, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL clr_new_frame: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd9, 4'd5, 4'd6, 4'd0, 1'b0});
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL clr_hold: valid/ready=%b expected 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] v[8];
    v = '{4'd2, 4'd2, 4'd5, 4'd1, 4'd5, 4'd1, 4'd2, 4'd2};
    send_one(4'd5); send_one(4'd12); send_one(4'd3);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (snap8() !== {1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got %h expected %h", snap8(), {1'b0, 1'b1, 17'd0});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send_one(v[i]);
    total++;
    if (snap8() !== {1'b1, 1'b0, 4'd5, 4'd2, 4'd1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_frame: got %h expected %h", snap8(), {1'b1, 1'b0, 4'd5, 4'd2, 4'd1, 4'd3, 1'b0});
    end
    release_result("async_reset");
  endtask

  task automatic test_len16();
    for (int i = 0; i < 16; i++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = 4'(15 - i);
      tick();
      if (i == 14) begin
        total++;
        if (bus16.out_valid !== 1'b0) begin
          bad++;
          $display("FAIL len16_early_valid: out_valid=%b expected 0", bus16.out_valid);
        end
      end
    end
    bus16.in_valid = 1'b0;
    total++;
    if (snap16() !== {1'b1, 1'b0, 4'd15, 4'd0, 4'd0, 4'd15, 1'b0}) begin
      bad++;
      $display("FAIL len16_result: got %h expected %h", snap16(), {1'b1, 1'b0, 4'd15, 4'd0, 4'd0, 4'd15, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_all_equal();
    test_back_pressure();
    test_gaps();
    test_clr();
    test_async_reset();
    test_len16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_minmax_tracker.md
FRAME_MINMAX_TRACKER -- requirements
Module: frame_minmax_tracker

Interface
REQ-001 Parameter FRAME_LEN, default 8, sets the number of 4-bit samples per frame; the legal range SHALL be 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 clr  input  1  synchronous frame abort.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  4  unsigned sample.
REQ-008 out_valid  output  1  frame result valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_max, out_min  output  4 each  largest and smallest sample in the frame.
REQ-011 out_max_idx, out_min_idx  output  4 each  frame position (0-based) of the first occurrence of each extreme.
REQ-012 out_all_equal  output  1  all samples in the frame are identical.

Function
REQ-013 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-014 States SHALL be IDLE, ACCUM and HOLD.
REQ-015 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 IDLE->ACCUM on acceptance: load max=min=in_data, max_idx=min_idx=0, cnt=1, all_equal=1.
REQ-018 In ACCUM, each accepted sample SHALL be compared unsigned against the stored max and stored min.
REQ-019 Max and max_idx SHALL update only on strictly greater; min and min_idx only on strictly less; first occurrence wins on ties.
REQ-020 all_equal SHALL clear on any accepted sample not equal to the stored max.
REQ-021 ACCUM->HOLD on acceptance of sample number FRAME_LEN (cnt==FRAME_LEN-1); the result SHALL appear with out_valid=1 on the next cycle, i.e. latency 1.
REQ-022 HOLD->IDLE when out_ready=1.
REQ-023 No sample SHALL be accepted in the HOLD-exit cycle, giving exactly one idle bubble per frame.
REQ-024 Result outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 ACCUM cycles with in_valid=0 SHALL hold all state; there SHALL be no timeout.
REQ-026 clr=1 in ACCUM or HOLD SHALL return to IDLE next cycle, discarding the partial or held frame.
REQ-027 clr SHALL take priority over acceptance and over out_ready in the same cycle.
REQ-028 The index counter SHALL be 4 bits and never wrap within a frame; FRAME_LEN=16 SHALL reach index 15.
REQ-029 Equal samples SHALL alter neither index.

Reset
REQ-030 rst=1 SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, out_max=0, out_min=0, out_max_idx=0, out_min_idx=0, out_all_equal=0, cnt=0.
REQ-031 Reset mid-frame SHALL discard all partial results.
REQ-032 The first edge after rst deassertion SHALL already accept a sample.

Structure
REQ-033 The state encoding (IDLE/ACCUM/HOLD), the data width constant (4) and the index width constant (4) SHALL live in the shared package frame_minmax_pkg.
REQ-034 Magnitude compare SHALL use two instances of the existing four_bit_comparator sub-module: one sample-vs-max, one sample-vs-min.
REQ-035 The block SHALL use their A_greater_than_B, B_greater_than_A and equal outputs directly, with no duplicate compare logic.

Verification
REQ-036 FRAME_LEN=8, samples 3,9,1,9,0,15,15,2 back-to-back -> one cycle after the last sample: max=15 idx=5, min=0 idx=4, all_equal=0.
REQ-037 Eight samples of 7 -> max=min=7, both idx=0, all_equal=1.
REQ-038 Hold out_ready=0 for 5 cycles after result -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle, next frame accepted cycle after.
REQ-039 in_valid toggled 1,0,0,1 pattern across a frame -> result identical to the gapless frame, and out_valid rises exactly one cycle after the 8th acceptance.
REQ-040 Assert clr after 4 samples, then send 8 new samples -> result reflects only the new frame.
REQ-041 Assert rst asynchronously mid-ACCUM (between edges) -> outputs zero immediately, and the next frame is correct.
REQ-042 FRAME_LEN=16 with a strictly descending input 15..0 -> max idx=0, min idx=15.
